pwm_word_loader: RTL and testbench
==================================

Name: pwm_word_loader

Overview:
Load-control stage directly upstream of the vernier PWM generator, clocked on the 200 MHz core clock.
- Accepts PWM command words (A/B counter limits) over a valid/ready handshake and range-checks them.
- Holds one accepted word in a staging register.
- Generates the 1 MHz load strobe clkZ, the counter enable and the latch reset.
- Presents new A_val/B_val only at a frame point where they are stable for the next clkZ rising edge.

Parameters:
CORE_DIV, 200, clkCore cycles per load frame; even, >= 4; HALF = CORE_DIV/2
VAL_W, 7, width of A_val/B_val
A_MAX, 79, largest legal A value (80 clkA cycles per 1 us frame)
B_MAX, 80, largest legal B value (81 clkB cycles per 1 us frame)

Ports:
clkCore  in  1  200 MHz core clock
reset  in  1  asynchronous, active-low reset
cmd_word  in  2*VAL_W  [2*VAL_W-1:VAL_W]=A, [VAL_W-1:0]=B
cmd_valid  in  1  command word present
cmd_ready  out  1  loader can accept a word
run  in  1  request PWM counting enabled
err_clr  in  1  clears err
clkZ  out  1  load strobe to counters, 50% duty, period CORE_DIV
A_val  out  VAL_W  applied A limit
B_val  out  VAL_W  applied B limit
en  out  1  counter/comparator enable
pwm_reset  out  1  one-cycle pulse resetting the RS latch on word apply
applied  out  1  one-cycle pulse: staged word transferred to outputs
err  out  1  sticky: out-of-range word rejected

Behaviour:
- Reset values (all registers, asserted asynchronously when reset=0):
  - Frame counter cnt = CORE_DIV-1.
  - clkZ, A_val, B_val, en, pwm_reset, applied, err, cmd_ready = 0.
  - Staging register empty.
- Frame counter: cnt increments each clkCore edge and wraps CORE_DIV-1 -> 0.
  - clkZ is registered: 1 when post-edge cnt is in [0, HALF-1], else 0.
  - The first clkZ rising edge occurs on the first clkCore edge after reset release.
- Apply point: the edge on which cnt becomes HALF, i.e. the clkZ falling edge. Values change a half-frame before the next clkZ rising edge.
- cmd_ready is registered, equal to "staging empty". It goes to 1 on the first edge after reset release.
- Accept: occurs on an edge with cmd_valid=1 and cmd_ready=1.
  - If A <= A_MAX and B <= B_MAX: the word is staged and cmd_ready=0 from the next cycle (state PENDING).
  - Otherwise the word is consumed but discarded: err=1, staging stays empty, cmd_ready stays 1.
- FSM:
  - IDLE -> PENDING on a legal accept.
  - PENDING -> IDLE at the apply point.
  - In PENDING, cmd_ready=0; the producer holds its word (backpressure, no overwrite).
- At the apply point in PENDING:
  - A_val/B_val are updated from staging.
  - pwm_reset=1 and applied=1 for exactly one cycle.
  - Staging is emptied; cmd_ready=1 on the following edge.
- Simultaneous accept and apply point: the word accepted on the edge where cnt becomes HALF is not applied in that frame. It applies at the next apply point, CORE_DIV cycles later.
- No staged word at the apply point: outputs hold, no pulses.
- en: set to run, sampled at every apply point (independent of staging). Mid-frame run changes take effect only at the next apply point.
- err: stays 1 until err_clr=1 (clears on the next edge). If err_clr and a rejected word occur on the same edge, err=1 (set wins).
- Reset mid-operation: the staged word is lost and outputs return to reset values immediately. After release, the frame restarts per the reset-value rule.
- Range check is unsigned. Values equal to A_MAX/B_MAX are legal.

Test Plan:
(All with CORE_DIV=200.)
1. Release reset, idle 1000 cycles -> clkZ rises on the 1st edge, high 100/low 100 cycles, period 200. A_val=B_val=0, en=0. cmd_ready=1 from the 1st edge.
2. Send A=40, B=41 at cnt=10 -> cmd_ready=0 next cycle. A_val=40 and B_val=41 appear on the edge where cnt becomes 100. pwm_reset and applied each pulse for 1 cycle. cmd_ready=1 one cycle later.
3. Accept A=5, B=6 on the edge where cnt becomes 100 -> no update that frame. Applied exactly 200 cycles later. A second word held valid meanwhile sees cmd_ready=0 and is not accepted.
4. Send A=80, B=10 -> handshake completes, err=1, A_val/B_val unchanged, no pwm_reset. Then send A=79, B=80 -> applied normally. Pulse err_clr -> err=0.
5. Raise run at cnt=150 -> en=1 at the next edge where cnt becomes 100. Drop run at cnt=20 -> en=0 at the following apply point.
6. Assert reset while PENDING (word A=30, B=31 staged) -> all outputs 0 immediately. After release, no apply occurs; A_val=B_val=0 and cmd_ready=1.

Source files
------------

// File: rtl/pwm_word_loader.sv
// -----------------------------------------------------------------------------
// pwm_word_loader
//
// Load-control stage in front of the vernier PWM generator. It runs on the core
// clock and does four jobs:
//   * accepts A/B counter-limit command words over a valid/ready handshake and
//     range-checks them
//   * holds one accepted word in a staging register
//   * generates the frame strobe clkZ (50 % duty, period CORE_DIV), the counter
//     enable and the RS-latch reset pulse
//   * moves the staged word onto A_val/B_val at the clkZ falling edge, so the
//     new limits have been stable for half a frame when clkZ next rises
//
// Ports
//   clkCore    in   core clock
//   reset      in   asynchronous, active-low reset
//   cmd_word   in   command word, [2*VAL_W-1:VAL_W] = A, [VAL_W-1:0] = B
//   cmd_valid  in   command word present
//   cmd_ready  out  loader can accept a word (registered)
//   run        in   request PWM counting enabled
//   err_clr    in   clears the sticky error flag
//   clkZ       out  load strobe, high for the first half of each frame
//   A_val      out  applied A limit
//   B_val      out  applied B limit
//   en         out  counter/comparator enable, sampled from run per frame
//   pwm_reset  out  one-cycle pulse when a word is applied
//   applied    out  one-cycle pulse when a word is applied
//   err        out  sticky flag: an out-of-range word was rejected
// -----------------------------------------------------------------------------
module pwm_word_loader #(
  parameter int CORE_DIV = 200,
  parameter int VAL_W    = 7,
  parameter int A_MAX    = 79,
  parameter int B_MAX    = 80
) (
  input  logic               clkCore,
  input  logic               reset,
  input  logic [2*VAL_W-1:0] cmd_word,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               run,
  input  logic               err_clr,
  output logic               clkZ,
  output logic [VAL_W-1:0]   A_val,
  output logic [VAL_W-1:0]   B_val,
  output logic               en,
  output logic               pwm_reset,
  output logic               applied,
  output logic               err
);

  localparam int HALF  = CORE_DIV / 2;
  localparam int CNT_W = (CORE_DIV > 2) ? $clog2(CORE_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [VAL_W-1:0] A_LIM    = VAL_W'(A_MAX);
  localparam logic [VAL_W-1:0] B_LIM    = VAL_W'(B_MAX);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Unsigned range check; the limits themselves are legal values.
  function automatic logic word_legal(input logic [VAL_W-1:0] a,
                                      input logic [VAL_W-1:0] b);
    return (a <= A_LIM) && (b <= B_LIM);
  endfunction

  // Frame counter successor with wrap from CORE_DIV-1 back to 0.
  function automatic logic [CNT_W-1:0] cnt_succ(input logic [CNT_W-1:0] c);
    return (c == CNT_LAST) ? '0 : c + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               clkz_q,      clkz_d;
  logic [VAL_W-1:0]   stg_a_q,     stg_a_d;
  logic [VAL_W-1:0]   stg_b_q,     stg_b_d;
  logic [VAL_W-1:0]   a_val_q,     a_val_d;
  logic [VAL_W-1:0]   b_val_q,     b_val_d;
  logic               en_q,        en_d;
  logic               pwm_reset_q, pwm_reset_d;
  logic               applied_q,   applied_d;
  logic               err_q,       err_d;
  logic               cmd_ready_q, cmd_ready_d;

  // Decoded per-cycle events
  logic [VAL_W-1:0]   cmd_a;
  logic [VAL_W-1:0]   cmd_b;
  logic               apply_pt;
  logic               accept;
  logic               accept_ok;
  logic               reject;
  logic               do_apply;

  always_comb begin
    cmd_a = cmd_word[2*VAL_W-1:VAL_W];
    cmd_b = cmd_word[VAL_W-1:0];

    cnt_d = cnt_succ(cnt_q);

    // clkZ is decoded from the post-edge count so the register output is high
    // exactly while the counter sits in the first half of the frame.
    clkz_d = (cnt_d < CNT_HALF);

    // Apply point: the edge that moves the count to HALF (clkZ falling edge).
    apply_pt = (cnt_d == CNT_HALF);

    // cmd_ready_q is only ever 1 in IDLE, so a handshake can never overwrite a
    // staged word.
    accept    = cmd_valid && cmd_ready_q;
    accept_ok = accept && word_legal(cmd_a, cmd_b);
    reject    = accept && !word_legal(cmd_a, cmd_b);

    // Only a word that was already staged before this edge is applied; a word
    // accepted on the apply edge itself waits for the next frame.
    do_apply = (state_q == S_PENDING) && apply_pt;

    state_d = state_q;
    stg_a_d = stg_a_q;
    stg_b_d = stg_b_q;
    case (state_q)
      S_IDLE: begin
        if (accept_ok) begin
          state_d = S_PENDING;
          stg_a_d = cmd_a;
          stg_b_d = cmd_b;
        end
      end
      S_PENDING: begin
        if (apply_pt) begin
          state_d = S_IDLE;
          stg_a_d = '0;
          stg_b_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    a_val_d     = do_apply ? stg_a_q : a_val_q;
    b_val_d     = do_apply ? stg_b_q : b_val_q;
    pwm_reset_d = do_apply;
    applied_d   = do_apply;

    // run is sampled once per frame, whether or not a word is staged.
    en_d = apply_pt ? run : en_q;

    // Sticky error; a rejection on the same edge as err_clr keeps it set.
    if (reject) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    // Ready follows the state of the previous cycle, so after an apply it
    // returns one edge after the pulses; a legal accept drops it immediately.
    cmd_ready_d = (state_q == S_IDLE) && !accept_ok;
  end

  always_ff @(posedge clkCore or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_LAST;
      clkz_q      <= 1'b0;
      stg_a_q     <= '0;
      stg_b_q     <= '0;
      a_val_q     <= '0;
      b_val_q     <= '0;
      en_q        <= 1'b0;
      pwm_reset_q <= 1'b0;
      applied_q   <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clkz_q      <= clkz_d;
      stg_a_q     <= stg_a_d;
      stg_b_q     <= stg_b_d;
      a_val_q     <= a_val_d;
      b_val_q     <= b_val_d;
      en_q        <= en_d;
      pwm_reset_q <= pwm_reset_d;
      applied_q   <= applied_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign clkZ      = clkz_q;
  assign A_val     = a_val_q;
  assign B_val     = b_val_q;
  assign en        = en_q;
  assign pwm_reset = pwm_reset_q;
  assign applied   = applied_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pwm_word_loader.sv
// -----------------------------------------------------------------------------
// tb_pwm_word_loader
//
// Directed bench for pwm_word_loader with CORE_DIV = 200. The bench keeps its
// own model of the frame count (cnt_m = count after the most recent edge) and
// drives/samples 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_word_loader;

  localparam int CORE_DIV = 200;
  localparam int VAL_W    = 7;

  logic               clkCore = 1'b0;
  logic               reset;
  logic [2*VAL_W-1:0] cmd_word;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               run;
  logic               err_clr;
  logic               clkZ;
  logic [VAL_W-1:0]   A_val;
  logic [VAL_W-1:0]   B_val;
  logic               en;
  logic               pwm_reset;
  logic               applied;
  logic               err;

  always #5 clkCore = ~clkCore;

  pwm_word_loader #(
    .CORE_DIV (CORE_DIV),
    .VAL_W    (VAL_W),
    .A_MAX    (79),
    .B_MAX    (80)
  ) dut (
    .clkCore   (clkCore),
    .reset     (reset),
    .cmd_word  (cmd_word),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .run       (run),
    .err_clr   (err_clr),
    .clkZ      (clkZ),
    .A_val     (A_val),
    .B_val     (B_val),
    .en        (en),
    .pwm_reset (pwm_reset),
    .applied   (applied),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;
  int cnt_m  = CORE_DIV - 1;

  typedef struct {
    logic [VAL_W-1:0] a;
    logic [VAL_W-1:0] b;
    logic             legal;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clkCore);
    #1;
    if (!reset) cnt_m = CORE_DIV - 1;
    else        cnt_m = (cnt_m == CORE_DIV - 1) ? 0 : cnt_m + 1;
  endtask

  task automatic go_to(input int c);
    for (int i = 0; i < CORE_DIV && cnt_m != c; i++) tick();
  endtask

  initial begin
    logic [VAL_W-1:0] pa;
    logic [VAL_W-1:0] pb;
    logic             err_exp;
    int               bad;
    int               rises;
    logic             prev_z;

    vecs[0] = '{a: 7'd40,  b: 7'd41,  legal: 1'b1};
    vecs[1] = '{a: 7'd80,  b: 7'd10,  legal: 1'b0};
    vecs[2] = '{a: 7'd79,  b: 7'd80,  legal: 1'b1};
    vecs[3] = '{a: 7'd0,   b: 7'd0,   legal: 1'b1};
    vecs[4] = '{a: 7'd10,  b: 7'd81,  legal: 1'b0};
    vecs[5] = '{a: 7'd127, b: 7'd127, legal: 1'b0};
    vecs[6] = '{a: 7'd79,  b: 7'd81,  legal: 1'b0};
    vecs[7] = '{a: 7'd80,  b: 7'd80,  legal: 1'b0};
    vecs[8] = '{a: 7'd3,   b: 7'd80,  legal: 1'b1};

    reset     = 1'b0;
    cmd_word  = '0;
    cmd_valid = 1'b0;
    run       = 1'b0;
    err_clr   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_clkZ",      clkZ,      0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_A_val",     A_val,     0);
    chk("rst_B_val",     B_val,     0);
    chk("rst_en",        en,        0);
    chk("rst_pwm_reset", pwm_reset, 0);
    chk("rst_applied",   applied,   0);
    chk("rst_err",       err,       0);

    // Idle after release: clkZ rises on edge 1, 100 high / 100 low
    reset = 1'b1;
    tick();
    chk("idle_clkZ_first",  clkZ,      1);
    chk("idle_ready_first", cmd_ready, 1);
    bad    = 0;
    rises  = 1;
    prev_z = clkZ;
    for (int i = 1; i < 1000; i++) begin
      tick();
      if (clkZ !== ((cnt_m < CORE_DIV / 2) ? 1'b1 : 1'b0)) bad++;
      if (clkZ === 1'b1 && prev_z === 1'b0) rises++;
      prev_z = clkZ;
    end
    chk("idle_clkZ_pattern", bad,       0);
    chk("idle_clkZ_rises",   rises,     5);
    chk("idle_A_val",        A_val,     0);
    chk("idle_B_val",        B_val,     0);
    chk("idle_en",           en,        0);
    chk("idle_cmd_ready",    cmd_ready, 1);

    // Table: accept at cnt=10, observe the apply point around cnt=100
    pa      = '0;
    pb      = '0;
    err_exp = 1'b0;
    for (int i = 0; i < 9; i++) begin
      go_to(9);
      cmd_word  = {vecs[i].a, vecs[i].b};
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cmd_word  = '0;
      err_exp   = err_exp | !vecs[i].legal;
      chk($sformatf("v%0d_ready_after_accept", i), cmd_ready, vecs[i].legal ? 0 : 1);
      chk($sformatf("v%0d_err", i), err, err_exp);
      go_to(99);
      chk($sformatf("v%0d_A_before", i), A_val, pa);
      chk($sformatf("v%0d_applied_before", i), applied, 0);
      tick();
      chk($sformatf("v%0d_applied", i),   applied,   vecs[i].legal);
      chk($sformatf("v%0d_pwm_reset", i), pwm_reset, vecs[i].legal);
      chk($sformatf("v%0d_A_val", i), A_val, vecs[i].legal ? vecs[i].a : pa);
      chk($sformatf("v%0d_B_val", i), B_val, vecs[i].legal ? vecs[i].b : pb);
      chk($sformatf("v%0d_ready_at_apply", i), cmd_ready, vecs[i].legal ? 0 : 1);
      if (vecs[i].legal) begin
        pa = vecs[i].a;
        pb = vecs[i].b;
      end
      tick();
      chk($sformatf("v%0d_applied_after", i),   applied,   0);
      chk($sformatf("v%0d_pwm_reset_after", i), pwm_reset, 0);
      chk($sformatf("v%0d_ready_after", i),     cmd_ready, 1);
    end

    // err_clr
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_err", err, 0);

    // Accept on the apply edge: applies one full frame later; a second word
    // held valid meanwhile is not taken
    go_to(99);
    cmd_word  = {7'd5, 7'd6};
    cmd_valid = 1'b1;
    tick();
    chk("simul_no_apply", applied,   0);
    chk("simul_A_hold",   A_val,     pa);
    chk("simul_ready",    cmd_ready, 0);
    cmd_word = {7'd7, 7'd8};
    bad = 0;
    for (int i = 0; i < CORE_DIV - 1; i++) begin
      tick();
      if (cmd_ready !== 1'b0) bad++;
      if (applied !== 1'b0) bad++;
    end
    chk("simul_backpressure", bad,   0);
    chk("simul_A_still_old",  A_val, pa);
    tick();
    chk("simul_A_applied",  A_val,   5);
    chk("simul_B_applied",  B_val,   6);
    chk("simul_applied",    applied, 1);
    cmd_valid = 1'b0;
    cmd_word  = '0;
    go_to(99);
    tick();
    chk("simul_second_not_taken_A", A_val,   5);
    chk("simul_second_not_taken_B", B_val,   6);
    chk("simul_no_second_apply",    applied, 0);

    // run sampled only at the apply point
    go_to(149);
    run = 1'b1;
    tick();
    chk("run_en_mid", en, 0);
    go_to(99);
    chk("run_en_before", en, 0);
    tick();
    chk("run_en_set", en, 1);
    go_to(19);
    run = 1'b0;
    tick();
    chk("run_en_hold", en, 1);
    go_to(99);
    chk("run_en_hold2", en, 1);
    tick();
    chk("run_en_clr", en, 0);

    // Rejection and err_clr on the same edge: set wins, ready stays up
    go_to(9);
    cmd_word  = {7'd100, 7'd0};
    cmd_valid = 1'b1;
    err_clr   = 1'b1;
    tick();
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    cmd_word  = '0;
    chk("setwins_err",   err,       1);
    chk("setwins_ready", cmd_ready, 1);

    // Reset while PENDING
    run = 1'b1;
    go_to(100);
    chk("pre_rst_en", en, 1);
    go_to(9);
    cmd_word  = {7'd30, 7'd31};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_word  = '0;
    chk("pend_ready", cmd_ready, 0);
    go_to(50);
    reset = 1'b0;
    #1;
    chk("midrst_clkZ",      clkZ,      0);
    chk("midrst_A_val",     A_val,     0);
    chk("midrst_B_val",     B_val,     0);
    chk("midrst_en",        en,        0);
    chk("midrst_err",       err,       0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_applied",   applied,   0);
    chk("midrst_pwm_reset", pwm_reset, 0);
    tick();
    tick();
    run   = 1'b0;
    reset = 1'b1;
    tick();
    chk("rerel_clkZ",  clkZ,      1);
    chk("rerel_ready", cmd_ready, 1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (applied !== 1'b0 || pwm_reset !== 1'b0) bad++;
    end
    chk("rerel_no_apply", bad,       0);
    chk("rerel_A_val",    A_val,     0);
    chk("rerel_B_val",    B_val,     0);
    chk("rerel_ready2",   cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
